// File: rtl/reset_sequencer.sv
// reset_sequencer: system reset generator.
// Combines power-on/PLL-lock reset, the debounced push-button and the host DTR edge.
// It releases the peripheral reset first and the CPU reset CPU_DELAY_CYCLES later.
// It also records the cause of the most recent reset.
// Optional feature macro: RESET_SEQ_DTR_EN. When it is not defined, the uart_dtr
// input is ignored and reset_cause never reads 2.
//
// state        | meaning
// -------------|---------------------------------------------------------
// ST_PERIPH_RST| peripherals and CPU held in reset, counting PERIPH_RST_CYCLES
// ST_CPU_WAIT  | peripherals released, CPU held, counting CPU_DELAY_CYCLES
// ST_RUN       | everything released
module reset_sequencer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int PERIPH_RST_CYCLES = 2500,
  parameter int CPU_DELAY_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nreset,
  input  logic       uart_dtr,
  output logic       sys_reset,
  output logic       periph_reset,
  output logic       nrst_out,
  output logic [1:0] reset_cause,
  output logic       seq_busy
);

  localparam int MAX_CYC = (PERIPH_RST_CYCLES > CPU_DELAY_CYCLES) ? PERIPH_RST_CYCLES
                                                                  : CPU_DELAY_CYCLES;
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_DTR = 2'd2;

  typedef enum logic [1:0] {
    ST_PERIPH_RST = 2'd0,
    ST_CPU_WAIT   = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        cause_nxt;
  logic              sys_nxt, periph_nxt, busy_nxt;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   btn_s;
  logic                   btn_db;
  logic [DB_W-1:0]        db_cnt;
  logic                   btn_trig;
  logic                   dtr_trig;

  // Button synchroniser: loads "released" during reset so no trigger is seen at power-up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync <= '1;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], nreset};
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1];

  // Debounce: accept a new button level only after DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_trig = ~btn_db;

`ifdef RESET_SEQ_DTR_EN
  logic [SYNC_STAGES-1:0] dtr_sync;
  logic                   dtr_prev;

  // DTR synchroniser plus previous-value flop for falling-edge detection; idle level is 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dtr_sync <= '1;
      dtr_prev <= 1'b1;
    end else begin
      dtr_sync <= {dtr_sync[SYNC_STAGES-2:0], uart_dtr};
      dtr_prev <= dtr_sync[SYNC_STAGES-1];
    end
  end

  assign dtr_trig = dtr_prev & ~dtr_sync[SYNC_STAGES-1];
`else
  logic unused_dtr;
  assign unused_dtr = uart_dtr;
  assign dtr_trig   = 1'b0;
`endif

  // State, shared counter, cause and registered outputs (decoded from the next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_PERIPH_RST;
      cnt          <= '0;
      reset_cause  <= CAUSE_POR;
      sys_reset    <= 1'b1;
      periph_reset <= 1'b1;
      nrst_out     <= 1'b0;
      seq_busy     <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      reset_cause  <= cause_nxt;
      sys_reset    <= sys_nxt;
      periph_reset <= periph_nxt;
      nrst_out     <= ~periph_nxt;
      seq_busy     <= busy_nxt;
    end
  end

  // Next state: any trigger restarts the whole sequence, button has priority for the cause
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = reset_cause;
    if (btn_trig || dtr_trig) begin
      state_nxt = ST_PERIPH_RST;
      cnt_nxt   = '0;
      cause_nxt = btn_trig ? CAUSE_BTN : CAUSE_DTR;
    end else begin
      case (state)
        ST_PERIPH_RST: begin
          if (cnt == PERIPH_LAST) begin
            state_nxt = ST_CPU_WAIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_CPU_WAIT: begin
          if (cnt == CPU_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = ST_PERIPH_RST;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs move on the same edge as the state
  always_comb begin
    sys_nxt    = (state_nxt != ST_RUN);
    periph_nxt = (state_nxt == ST_PERIPH_RST);
    busy_nxt   = (state_nxt != ST_RUN);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (SYNC=2, DEBOUNCE=8, PERIPH=16, CPU=4).
// Output vector = {sys_reset, periph_reset, nrst_out, seq_busy, reset_cause[1:0]}.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       nreset;
  logic       uart_dtr;
  logic       sys_reset;
  logic       periph_reset;
  logic       nrst_out;
  logic [1:0] reset_cause;
  logic       seq_busy;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .PERIPH_RST_CYCLES(16),
    .CPU_DELAY_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .nreset(nreset),
    .uart_dtr(uart_dtr),
    .sys_reset(sys_reset),
    .periph_reset(periph_reset),
    .nrst_out(nrst_out),
    .reset_cause(reset_cause),
    .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] vec;
  assign vec = {sys_reset, periph_reset, nrst_out, seq_busy, reset_cause};

  logic [5:0] prev;
  bit         seen = 1'b0;

  // Monitor: every change of the output vector must match the next expected event
  always @(negedge clk) begin
    if (!seen || vec !== prev) begin
      seen = 1'b1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b",
                 cyc, vec, prev);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (vec !== e.vec || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_bad++;
          $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                   e.name, vec, cyc, e.vec, e.cyc);
        end
      end
      prev = vec;
    end
  end

  task automatic expect_at(input int c, input logic [5:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // All expected events consumed and outputs resting at the given value
  task automatic check_steady(input string n, input logic [5:0] v);
    n_cmp++;
    if (sb.size() != 0 || vec !== v) begin
      n_bad++;
      $display("FAIL %s: got %b with %0d events pending, required %b with 0 pending",
               n, vec, sb.size(), v);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int t1;
    int t2;
    reset    = 1'b1;
    nreset   = 1'b1;
    uart_dtr = 1'b1;
    expect_at(-1, 6'b110100, "reset_state");

    // Power-on release
    step(3);
    reset = 1'b0;
    t = cyc;
    expect_at(t + 16, 6'b101100, "por_periph_release");
    expect_at(t + 20, 6'b001000, "por_sys_release");
    step(25);
    check_steady("por_run", 6'b001000);

    // Short glitch on the button is filtered
    nreset = 1'b0;
    step(5);
    nreset = 1'b1;
    step(15);
    check_steady("glitch_run", 6'b001000);

`ifdef RESET_SEQ_DTR_EN
    // DTR falling edge restarts the sequence, rising edge does nothing
    uart_dtr = 1'b0;
    t = cyc;
    expect_at(t + 3,  6'b110110, "dtr_assert");
    expect_at(t + 19, 6'b101110, "dtr_periph_release");
    expect_at(t + 23, 6'b001010, "dtr_sys_release");
    step(10);
    uart_dtr = 1'b1;
    step(20);
    check_steady("dtr_run", 6'b001010);
`else
    // DTR path absent: toggling must be ignored
    repeat (4) begin
      uart_dtr = 1'b0;
      step(3);
      uart_dtr = 1'b1;
      step(3);
    end
    step(5);
    check_steady("dtr_ignored", 6'b001000);
`endif

    // Button held for 30 cycles
    nreset = 1'b0;
    t = cyc;
    expect_at(t + 11, 6'b110101, "btn_assert");
    step(30);
    check_steady("btn_held", 6'b110101);
    nreset = 1'b1;
    t1 = cyc;
    expect_at(t1 + 26, 6'b101101, "btn_periph_release");
    expect_at(t1 + 30, 6'b001001, "btn_sys_release");
    step(35);
    check_steady("btn_run", 6'b001001);

`ifdef RESET_SEQ_DTR_EN
    // DTR edge arriving during CPU_WAIT restarts the full sequence
    uart_dtr = 1'b0;
    t = cyc;
    expect_at(t + 3,  6'b110110, "rst_dtr_assert");
    expect_at(t + 19, 6'b101110, "rst_cpu_wait_enter");
    step(10);
    uart_dtr = 1'b1;
    step(9);
    check_steady("cpu_wait", 6'b101110);
    uart_dtr = 1'b0;
    t2 = cyc;
    expect_at(t2 + 3,  6'b110110, "restart_assert");
    expect_at(t2 + 19, 6'b101110, "restart_periph_release");
    expect_at(t2 + 23, 6'b001010, "restart_sys_release");
    step(10);
    uart_dtr = 1'b1;
    step(20);
    check_steady("restart_run", 6'b001010);
`endif

    // Debounced button and DTR edge land on the same cycle: button wins
    nreset = 1'b0;
    t = cyc;
    step(8);
    uart_dtr = 1'b0;
    expect_at(t + 11, 6'b110101, "simul_btn_wins");
    step(12);
    nreset = 1'b1;
    t1 = cyc;
    expect_at(t1 + 26, 6'b101101, "simul_periph_release");
    expect_at(t1 + 30, 6'b001001, "simul_sys_release");
    step(5);
    uart_dtr = 1'b1;
    step(30);
    check_steady("simul_run", 6'b001001);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
